// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the shift-and-add multiplier controller.
//   mult_state_t  : controller state encoding (also exported on the debug port)
//   DEFAULT_WIDTH : default operand width in bits
//   count_bits()  : width of a step counter able to hold 0..width
// -----------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ADD   = 3'd2,
        S_SHIFT = 3'd3,
        S_HALT  = 3'd4
    } mult_state_t;

    localparam int DEFAULT_WIDTH = 8;

    // The counter has to reach WIDTH itself (the value after the final shift),
    // so it needs one more code than WIDTH-1.
    function automatic int count_bits(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_step_counter.sv
// -----------------------------------------------------------------------------
// mult_step_counter
// Counts completed add/shift steps of one multiply.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset, forces count to 0
//   clear  in   restart the count at 0 (start of a multiply)
//   inc    in   one step finished (asserted in the shift cycle)
//   count  out  current step index, 0..WIDTH
//   last   out  terminal count: count == WIDTH-1, i.e. this is the final step
// -----------------------------------------------------------------------------
module mult_step_counter
    import mult_pkg::*;
#(
    parameter int  WIDTH = DEFAULT_WIDTH,
    localparam int CW    = count_bits(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          last
);

    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
    localparam logic [CW-1:0] MAX_COUNT = CW'(WIDTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != MAX_COUNT)) begin
            // Saturates at WIDTH so a stray increment can never wrap to 0.
            count <= count + CW'(1);
        end
    end

    assign last = (count == LAST_STEP);

endmodule

// File: rtl/mult_control_n.sv
// -----------------------------------------------------------------------------
// mult_control_n
// Control FSM for an N-bit shift-and-add multiplier (X:A:B datapath).
// One multiply = CLEAR, then WIDTH pairs of ADD/SHIFT, then HALT with Done.
// Latency from entering CLEAR to Done is fixed at 2*WIDTH+1 cycles.
// WIDTH must lie in 2..32.
//
// Parameters:
//   WIDTH   operand width in bits
//   SIGNED  1: two's-complement (last step subtracts), 0: unsigned (all add)
// Ports:
//   Clk           in   rising-edge clock
//   reset         in   synchronous active-high reset
//   ClearA_LoadB  in   clear A / load B request, only acted on in IDLE
//   Run           in   level start request
//   M             in   multiplier LSB B[0] from the datapath
//   ClrA          out  clear A and X
//   LoadB         out  load B from switches
//   Add_en        out  A <= A + S
//   Sub_en        out  A <= A - S
//   Shift_en      out  arithmetic right shift of X:A:B
//   Busy          out  multiply in progress (CLEAR/ADD/SHIFT)
//   Done          out  product valid, held while Run stays high
//   state_dbg     out  current FSM state (mult_state_t encoding)
//   count_dbg     out  current step counter value
//
// Handshake: Run is a level request. It is sampled only in IDLE (start) and
// HALT (release); Done stays high until Run is seen low, and holding Run high
// never starts a second multiply.
//
// All control outputs are combinational decodes of state, counter, M and
// reset so the datapath acts in the same cycle the state is entered.
// -----------------------------------------------------------------------------
module mult_control_n
    import mult_pkg::*;
#(
    parameter int  WIDTH  = DEFAULT_WIDTH,
    parameter int  SIGNED = 1,
    localparam int CW     = count_bits(WIDTH)
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic          ClearA_LoadB,
    input  logic          Run,
    input  logic          M,
    output logic          ClrA,
    output logic          LoadB,
    output logic          Add_en,
    output logic          Sub_en,
    output logic          Shift_en,
    output logic          Busy,
    output logic          Done,
    output logic [2:0]    state_dbg,
    output logic [CW-1:0] count_dbg
);

    mult_state_t   state;
    logic [CW-1:0] count;
    logic          last;
    logic          cnt_clear;
    logic          cnt_inc;

    // -------------------------------------------------------------------------
    // Step counter
    // -------------------------------------------------------------------------
    assign cnt_clear = (state == S_CLEAR);
    assign cnt_inc   = (state == S_SHIFT);

    mult_step_counter #(
        .WIDTH (WIDTH)
    ) u_step_counter (
        .clk   (Clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .count (count),
        .last  (last)
    );

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    // Run wins over ClearA_LoadB; the load is simply dropped.
                    if (Run) begin
                        state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    state <= S_ADD;
                end
                S_ADD: begin
                    // Always one cycle regardless of M to keep latency fixed.
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    // 'last' reflects the pre-increment count.
                    if (last) begin
                        state <= S_HALT;
                    end else begin
                        state <= S_ADD;
                    end
                end
                S_HALT: begin
                    if (!Run) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        ClrA     = 1'b0;
        LoadB    = 1'b0;
        Add_en   = 1'b0;
        Sub_en   = 1'b0;
        Shift_en = 1'b0;
        Busy     = 1'b0;
        Done     = 1'b0;
        if (reset) begin
            // Clear the datapath registers alongside the controller.
            ClrA  = 1'b1;
            LoadB = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ClearA_LoadB && !Run) begin
                        ClrA  = 1'b1;
                        LoadB = 1'b1;
                    end
                end
                S_CLEAR: begin
                    ClrA = 1'b1;
                    Busy = 1'b1;
                end
                S_ADD: begin
                    Busy = 1'b1;
                    if (M) begin
                        // The multiplier MSB has negative weight in
                        // two's complement, so its partial product subtracts.
                        if ((SIGNED != 0) && last) begin
                            Sub_en = 1'b1;
                        end else begin
                            Add_en = 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    Shift_en = 1'b1;
                    Busy     = 1'b1;
                end
                S_HALT: begin
                    Done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign state_dbg = state;
    assign count_dbg = count;

endmodule

// File: tb/tb_mult_control_n.sv
// -----------------------------------------------------------------------------
// tb_mult_control_n
// Three controller instances: WIDTH=8 signed, WIDTH=8 unsigned, WIDTH=16
// signed. Each multiply pushes its expected per-cycle output vector
// {ClrA,LoadB,Add_en,Sub_en,Shift_en,Busy,Done} into exp_q; the vectors are
// popped and compared as the DUT steps through the operation.
// -----------------------------------------------------------------------------
module tb_mult_control_n;
    import mult_pkg::*;

    localparam int N = 3;

    // ---------------------------------------------------------------- clock
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT io
    logic rst_i[N];
    logic clr_ld_i[N];
    logic run_i[N];
    logic m_i[N];
    logic clra_o[N];
    logic loadb_o[N];
    logic add_o[N];
    logic sub_o[N];
    logic shift_o[N];
    logic busy_o[N];
    logic done_o[N];
    logic [2:0] state_o[N];
    logic [3:0] cnt0;
    logic [3:0] cnt1;
    logic [4:0] cnt2;

    int wid[N] = '{8, 8, 16};
    int sgn[N] = '{1, 0, 1};

    logic [6:0] exp_q[$];
    int checks   = 0;
    int failures = 0;
    logic [2:0] idle_code = S_IDLE;

    mult_control_n #(.WIDTH(8), .SIGNED(1)) u_w8s (
        .Clk(clk), .reset(rst_i[0]), .ClearA_LoadB(clr_ld_i[0]), .Run(run_i[0]),
        .M(m_i[0]), .ClrA(clra_o[0]), .LoadB(loadb_o[0]), .Add_en(add_o[0]),
        .Sub_en(sub_o[0]), .Shift_en(shift_o[0]), .Busy(busy_o[0]),
        .Done(done_o[0]), .state_dbg(state_o[0]), .count_dbg(cnt0)
    );

    mult_control_n #(.WIDTH(8), .SIGNED(0)) u_w8u (
        .Clk(clk), .reset(rst_i[1]), .ClearA_LoadB(clr_ld_i[1]), .Run(run_i[1]),
        .M(m_i[1]), .ClrA(clra_o[1]), .LoadB(loadb_o[1]), .Add_en(add_o[1]),
        .Sub_en(sub_o[1]), .Shift_en(shift_o[1]), .Busy(busy_o[1]),
        .Done(done_o[1]), .state_dbg(state_o[1]), .count_dbg(cnt1)
    );

    mult_control_n #(.WIDTH(16), .SIGNED(1)) u_w16s (
        .Clk(clk), .reset(rst_i[2]), .ClearA_LoadB(clr_ld_i[2]), .Run(run_i[2]),
        .M(m_i[2]), .ClrA(clra_o[2]), .LoadB(loadb_o[2]), .Add_en(add_o[2]),
        .Sub_en(sub_o[2]), .Shift_en(shift_o[2]), .Busy(busy_o[2]),
        .Done(done_o[2]), .state_dbg(state_o[2]), .count_dbg(cnt2)
    );

    // ---------------------------------------------------------------- helpers
    function automatic logic [6:0] obs(input int idx);
        return {clra_o[idx], loadb_o[idx], add_o[idx], sub_o[idx],
                shift_o[idx], busy_o[idx], done_o[idx]};
    endfunction

    function automatic int cnt_of(input int idx);
        case (idx)
            0:       return int'(cnt0);
            1:       return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    // Reference behaviour for cycle c after entering CLEAR (c=0).
    function automatic logic [6:0] exp_vec(input int w, input int s, input int c,
                                           input logic m);
        logic [6:0] e;
        int step;
        e = 7'b0;
        if (c == 0) begin
            e[6] = 1'b1;
            e[1] = 1'b1;
        end else if (c <= 2 * w) begin
            step = (c - 1) / 2;
            e[1] = 1'b1;
            if (c % 2 == 1) begin
                if (m && s == 1 && step == w - 1) e[3] = 1'b1;
                else if (m)                       e[4] = 1'b1;
            end else begin
                e[2] = 1'b1;
            end
        end else begin
            e[0] = 1'b1;
        end
        return e;
    endfunction

    // ---------------------------------------------------------------- driver
    // m_mode: 0 = M low, 1 = M high, 2 = random M plus random Run/ClearA_LoadB
    // toggles while busy. hold: Run held high for cycles c < hold.
    // clr_at: cycle to pulse ClearA_LoadB, -2 = together with the Run request.
    task automatic run_mult(input int idx, input int m_mode, input int hold,
                            input int clr_at, input string name);
        int w;
        int last_c;
        int n_add;
        int n_sub;
        int n_shift;
        int n_clr;
        int exp_add;
        int exp_sub;
        int done_at;
        logic m_seq[32];
        logic [6:0] e;
        logic [6:0] o;
        w       = wid[idx];
        last_c  = (hold > 2 * w + 1) ? hold : 2 * w + 1;
        n_add   = 0;
        n_sub   = 0;
        n_shift = 0;
        n_clr   = 0;
        exp_add = 0;
        exp_sub = 0;
        done_at = -1;
        for (int k = 0; k < w; k++) begin
            m_seq[k] = (m_mode == 2) ? 1'($urandom_range(0, 1)) : (m_mode == 1);
            if (m_seq[k] && sgn[idx] == 1 && k == w - 1) exp_sub++;
            else if (m_seq[k])                           exp_add++;
        end

        // Request cycle (still IDLE): Run has priority, nothing decoded.
        @(posedge clk); #1;
        run_i[idx]    = 1'b1;
        clr_ld_i[idx] = (clr_at == -2);
        m_i[idx]      = m_seq[0];
        @(negedge clk);
        checks++;
        if (obs(idx) !== 7'b0) begin
            failures++;
            $display("FAIL %s_request idx=%0d got=%b exp=%b", name, idx, obs(idx), 7'b0);
        end

        for (int c = 0; c <= last_c; c++) exp_q.push_back(exp_vec(w, sgn[idx], c,
                            (c % 2 == 1 && c < 2 * w) ? m_seq[(c - 1) / 2] : 1'b0));

        for (int c = 0; c <= last_c; c++) begin
            @(posedge clk); #1;
            if (c < hold)                     run_i[idx] = 1'b1;
            else if (m_mode == 2 && c < 2 * w + 1) run_i[idx] = 1'($urandom_range(0, 1));
            else                              run_i[idx] = 1'b0;
            if (m_mode == 2 && c < 2 * w + 1) clr_ld_i[idx] = 1'($urandom_range(0, 1));
            else                              clr_ld_i[idx] = (c == clr_at);
            if (c % 2 == 1 && c < 2 * w)      m_i[idx] = m_seq[(c - 1) / 2];
            else if (m_mode == 2)             m_i[idx] = 1'($urandom_range(0, 1));
            else                              m_i[idx] = (m_mode == 1);
            @(negedge clk);
            o = obs(idx);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL %s_vector idx=%0d cyc=%0d got=%b exp=%b", name, idx, c, o, e);
            end
            if (c >= 1) begin
                checks++;
                if (cnt_of(idx) != ((c <= 2 * w) ? (c - 1) / 2 : w)) begin
                    failures++;
                    $display("FAIL %s_count idx=%0d cyc=%0d got=%0d exp=%0d", name, idx, c,
                             cnt_of(idx), (c <= 2 * w) ? (c - 1) / 2 : w);
                end
            end
            if (o[6] && !o[5]) n_clr++;
            if (o[4]) n_add++;
            if (o[3]) n_sub++;
            if (o[2]) n_shift++;
            if (o[0] && done_at < 0) done_at = c;
        end

        // Run seen low in HALT: back to IDLE.
        @(posedge clk); #1;
        run_i[idx]    = 1'b0;
        clr_ld_i[idx] = 1'b0;
        @(negedge clk);
        checks++;
        if (state_o[idx] !== idle_code || obs(idx) !== 7'b0) begin
            failures++;
            $display("FAIL %s_back_idle idx=%0d got_state=%0d got=%b exp_state=%0d exp=%b",
                     name, idx, state_o[idx], obs(idx), idle_code, 7'b0);
        end

        checks++;
        if (done_at != 2 * w + 1) begin
            failures++;
            $display("FAIL %s_latency idx=%0d got=%0d exp=%0d", name, idx, done_at, 2 * w + 1);
        end
        checks++;
        if (n_clr != 1 || n_shift != w || n_add != exp_add || n_sub != exp_sub) begin
            failures++;
            $display("FAIL %s_totals idx=%0d got clr=%0d shift=%0d add=%0d sub=%0d exp clr=1 shift=%0d add=%0d sub=%0d",
                     name, idx, n_clr, n_shift, n_add, n_sub, w, exp_add, exp_sub);
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        for (int i = 0; i < N; i++) rst_i[i] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (obs(i) !== 7'b1100000) begin
                failures++;
                $display("FAIL reset_outputs idx=%0d got=%b exp=%b", i, obs(i), 7'b1100000);
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) rst_i[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (obs(i) !== 7'b0 || state_o[i] !== idle_code || cnt_of(i) != 0) begin
                failures++;
                $display("FAIL reset_release idx=%0d got=%b state=%0d cnt=%0d exp=%b state=%0d cnt=0",
                         i, obs(i), state_o[i], cnt_of(i), 7'b0, idle_code);
            end
        end
    endtask

    task automatic test_m0();
        run_mult(0, 0, 0, -1, "m0_signed8");
    endtask

    task automatic test_m1_signed();
        run_mult(0, 1, 0, -1, "m1_signed8");
    endtask

    task automatic test_m1_unsigned();
        run_mult(1, 1, 0, -1, "m1_unsigned8");
    endtask

    task automatic test_run_held();
        run_mult(0, 1, 40, -1, "run_held");
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        run_i[0] = 1'b1;
        m_i[0]   = 1'b0;
        for (int c = 0; c < 9; c++) exp_q.push_back(exp_vec(8, 1, c, 1'b0));
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            run_i[0] = 1'b0;
            @(negedge clk);
            checks++;
            if (obs(0) !== exp_q[0]) begin
                failures++;
                $display("FAIL reset_mid_vector cyc=%0d got=%b exp=%b", c, obs(0), exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        // Cycle 9 is the ADD of step 4.
        @(posedge clk); #1;
        rst_i[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (obs(0) !== 7'b1100000) begin
            failures++;
            $display("FAIL reset_mid_outputs got=%b exp=%b", obs(0), 7'b1100000);
        end
        @(posedge clk); #1;
        rst_i[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (state_o[0] !== idle_code || cnt_of(0) != 0 || busy_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_idle got state=%0d cnt=%0d busy=%b exp state=%0d cnt=0 busy=0",
                     state_o[0], cnt_of(0), busy_o[0], idle_code);
        end
        run_mult(0, 0, 0, -1, "after_reset");
    endtask

    task automatic test_clrld();
        run_mult(2, 1, 0, 11, "clrld_mid16");
        run_mult(2, 0, 0, -2, "run_and_clrld16");
        @(posedge clk); #1;
        clr_ld_i[2] = 1'b1;
        @(negedge clk);
        checks++;
        if (obs(2) !== 7'b1100000 || state_o[2] !== idle_code) begin
            failures++;
            $display("FAIL clrld_idle got=%b state=%0d exp=%b state=%0d",
                     obs(2), state_o[2], 7'b1100000, idle_code);
        end
        @(posedge clk); #1;
        clr_ld_i[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (obs(2) !== 7'b0 || state_o[2] !== idle_code) begin
            failures++;
            $display("FAIL clrld_idle_release got=%b state=%0d exp=%b state=%0d",
                     obs(2), state_o[2], 7'b0, idle_code);
        end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 6; r++) run_mult(r % N, 2, 0, -1, "back_to_back");
    endtask

    // ---------------------------------------------------------------- main
    initial begin
        for (int i = 0; i < N; i++) begin
            rst_i[i]    = 1'b1;
            clr_ld_i[i] = 1'b0;
            run_i[i]    = 1'b0;
            m_i[i]      = 1'b0;
        end
        test_reset();
        test_m0();
        test_m1_signed();
        test_m1_unsigned();
        test_run_held();
        test_reset_mid();
        test_clrld();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
